// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// state codes, opcodes, ALUOp codes and the control-word bundle.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ORIEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_MUL = 6'h18;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SHL  = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_mul_wait_counter.sv
// Down-counter that holds EXEC for a multi-cycle mul.
// Ports: clk_i, rst_i, load_i/load_val_i, dec_i, done_o (count==0).
module mul_wait_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core.
// Inputs: clk_i, rst_i, Op_i, funct_i, MemAck_i. Outputs: datapath
// strobes/selects, ALUOp_o, Illegal_o, State_o. Multi-cycle mul is
// compiled in with MULTICYCLE_MUL_EN.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic [5:0] funct_i,
  input  logic       MemAck_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic [1:0] PCSource_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic       Illegal_o,
  output logic [3:0] State_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctl;
  logic   hold_exec;

`ifdef MULTICYCLE_MUL_EN
  logic mul_done;
  logic mul_load;

  // Reload on every EXEC entry; only a mul consults the done flag.
  assign mul_load = (state_q == S_DECODE) && (Op_i == OP_RTYPE);

  mul_wait_counter u_mul_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (mul_load),
    .load_val_i (4'(MUL_LATENCY - 1)),
    .dec_i      (state_q == S_EXEC),
    .done_o     (mul_done)
  );

  assign hold_exec = (funct_i == FUNCT_MUL) && !mul_done;
`else
  logic unused_cfg;
  assign unused_cfg = ^{funct_i, 4'(MUL_LATENCY)};
  assign hold_exec  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (MemAck_i) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemAck_i) state_d = S_MEMWB;
      S_MEMWR:  if (MemAck_i) state_d = S_FETCH;
      S_EXEC:   if (!hold_exec) state_d = S_ALUWB;
      S_ADDIEX: state_d = S_IMMWB;
      S_ORIEX:  state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.ir_write  = MemAck_i;
        ctl.pc_write  = MemAck_i;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_SHL;
        unique case (Op_i)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
          OP_ADDI, OP_ORI, OP_J: ctl.illegal = 1'b0;
          default:               ctl.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_OUT;
      end
      S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_ORIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_OR;
      end
      S_IMMWB:  ctl.reg_write = 1'b1;
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      default: ctl = '0;
    endcase
    // Reset is synchronous, so the state register can still hold
    // stale state during the first reset cycle; mask it here.
    if (rst_i) ctl = '0;
  end

  assign PCWrite_o     = ctl.pc_write;
  assign PCWriteCond_o = ctl.pc_write_cond;
  assign PCSource_o    = ctl.pc_source;
  assign IorD_o        = ctl.iord;
  assign MemRead_o     = ctl.mem_read;
  assign MemWrite_o    = ctl.mem_write;
  assign IRWrite_o     = ctl.ir_write;
  assign MemtoReg_o    = ctl.mem_to_reg;
  assign RegDst_o      = ctl.reg_dst;
  assign RegWrite_o    = ctl.reg_write;
  assign ALUSrcA_o     = ctl.alu_src_a;
  assign ALUSrcB_o     = ctl.alu_src_b;
  assign ALUOp_o       = ctl.alu_op;
  assign Illegal_o     = ctl.illegal;
  assign State_o       = rst_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control.
// Expected per-cycle control words are queued per instruction.
module tb_multicycle_control;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       ack;

  logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, ill;
  logic [1:0] pcsrc, srcb, aluop;
  logic [3:0] st;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       ill;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic       ack;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;

  vec_t obs;
  assign obs = {pcw, pcwc, pcsrc, iord, mr, mw, irw, m2r,
                rdst, rw, srca, srcb, aluop, ill, st};

  multicycle_control #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .Op_i          (op),
    .funct_i       (funct),
    .MemAck_i      (ack),
    .PCWrite_o     (pcw),
    .PCWriteCond_o (pcwc),
    .PCSource_o    (pcsrc),
    .IorD_o        (iord),
    .MemRead_o     (mr),
    .MemWrite_o    (mw),
    .IRWrite_o     (irw),
    .MemtoReg_o    (m2r),
    .RegDst_o      (rdst),
    .RegWrite_o    (rw),
    .ALUSrcA_o     (srca),
    .ALUSrcB_o     (srcb),
    .ALUOp_o       (aluop),
    .Illegal_o     (ill),
    .State_o       (st)
  );

  always #5 clk = ~clk;

  function automatic vec_t model(logic [3:0] s, logic a,
                                 logic [5:0] o);
    vec_t v;
    v = '0;
    v.st = s;
    case (s)
      4'd0: begin
        v.mr = 1; v.srcb = 2'b01; v.irw = a; v.pcw = a;
      end
      4'd1: begin
        v.srcb = 2'b11;
        v.ill = !(o inside {6'h00, 6'h02, 6'h04, 6'h08,
                            6'h0D, 6'h23, 6'h2B});
      end
      4'd2:  begin v.srca = 1; v.srcb = 2'b10; end
      4'd3:  begin v.mr = 1; v.iord = 1; end
      4'd4:  begin v.rw = 1; v.m2r = 1; end
      4'd5:  begin v.mw = 1; v.iord = 1; end
      4'd6:  begin v.srca = 1; v.aluop = 2'b11; end
      4'd7:  begin v.rdst = 1; v.rw = 1; end
      4'd8: begin
        v.srca = 1; v.aluop = 2'b01; v.pcwc = 1; v.pcsrc = 2'b01;
      end
      4'd9:  begin v.srca = 1; v.srcb = 2'b10; end
      4'd10: begin v.srca = 1; v.srcb = 2'b10; v.aluop = 2'b10; end
      4'd11: v.rw = 1;
      4'd12: begin v.pcw = 1; v.pcsrc = 2'b10; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input vec_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive ack, compare at the falling edge, then advance.
  task automatic step(input string tag, input logic a, input vec_t exp);
    ack = a;
    @(negedge clk);
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic a);
    ent_t e;
    e.st = s;
    e.ack = a;
    sb.push_back(e);
  endtask

  task automatic run_instr(input string tag, input logic [5:0] o,
                           input logic [5:0] f, input int fw,
                           input int mwait);
    int n;
    ent_t e;
    op = o;
    funct = f;
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'b0);
    case (o)
      6'h23: begin
        push(4'd2, 1'b0);
        for (int i = 0; i < mwait; i++) push(4'd3, 1'b0);
        push(4'd3, 1'b1);
        push(4'd4, 1'b1);
      end
      6'h2B: begin
        push(4'd2, 1'b1);
        for (int i = 0; i < mwait; i++) push(4'd5, 1'b0);
        push(4'd5, 1'b1);
      end
      6'h00: begin
        n = 1;
`ifdef MULTICYCLE_MUL_EN
        if (f == 6'h18) n = MUL_LAT;
`endif
        for (int i = 0; i < n; i++) push(4'd6, 1'b1);
        push(4'd7, 1'b0);
      end
      6'h04: push(4'd8, 1'b1);
      6'h08: begin push(4'd9, 1'b0); push(4'd11, 1'b1); end
      6'h0D: begin push(4'd10, 1'b0); push(4'd11, 1'b0); end
      6'h02: push(4'd12, 1'b1);
      default: ;
    endcase
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step(tag, e.ack, model(e.st, e.ack, o));
    end
  endtask

  initial begin
    rst = 1'b1;
    op = 6'h00;
    funct = 6'h00;
    ack = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) step("reset", 1'b1, '0);
    rst = 1'b0;

    run_instr("lw", 6'h23, 6'h00, 0, 0);
    run_instr("lw_wait", 6'h23, 6'h00, 2, 1);
    run_instr("sw_wait", 6'h2B, 6'h00, 0, 3);
    run_instr("beq", 6'h04, 6'h00, 0, 0);
    run_instr("add", 6'h00, 6'h20, 1, 0);
    run_instr("mul", 6'h00, 6'h18, 0, 0);
    run_instr("addi", 6'h08, 6'h00, 0, 0);
    run_instr("ori", 6'h0D, 6'h00, 0, 0);
    run_instr("j", 6'h02, 6'h00, 0, 0);
    run_instr("illegal", 6'h3F, 6'h00, 0, 0);
    run_instr("mul2", 6'h00, 6'h18, 1, 0);

    // Reset mid-lw: abandon after MEMADR, outputs masked to zero.
    op = 6'h23;
    step("mid_f", 1'b1, model(4'd0, 1'b1, 6'h23));
    step("mid_d", 1'b1, model(4'd1, 1'b1, 6'h23));
    step("mid_a", 1'b1, model(4'd2, 1'b1, 6'h23));
    rst = 1'b1;
    step("mid_rst", 1'b1, '0);
    rst = 1'b0;
    step("post_rst", 1'b0, model(4'd0, 1'b0, 6'h23));
    run_instr("lw_after", 6'h23, 6'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
